// File: rtl/mdu_iter_pkg.sv
// Shared defines for the execute stage: ALU op codes, MDU op encodings, MDU FSM states.
package mdu_iter_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Bit 0 of the MDU op code marks the unsigned variants, bit 1 the divides.
    function automatic logic mdu_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic mdu_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // rem_in < divisor keeps a successful difference inside WIDTH bits.
    always_comb begin
        trial   = {rem_in, dvd_bit};
        q_bit   = (trial >= {1'b0, divisor});
        diff    = trial[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, sign fix-up in FIX.
// MDU_FAST_MUL_EN selects a single-cycle multiply that skips RUN.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    // acc holds {partial remainder, dividend/quotient} while dividing.
    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
        .dvd_bit (acc_q[WIDTH-1]),
        .divisor (mcand_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        sgn      = mdu_is_signed(op);
        mag_a    = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn && b[WIDTH-1]) ? -b : b;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d  = mdu_is_div(op);
                    neg_d     = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d = sgn && a[WIDTH-1];
                    dz_d      = mdu_is_div(op) && (b == '0);
                    mcand_d   = mdu_is_div(op) ? mag_b : mag_a;
                    acc_d     = {{WIDTH{1'b0}}, mdu_is_div(op) ? mag_a : mag_b};
                    cnt_d     = '0;
                    state_d   = ST_RUN;
`ifdef MDU_FAST_MUL_EN
                    if (!mdu_is_div(op)) begin
                        acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                        state_d = ST_FIX;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    acc_d = {step_rem, acc_q[WIDTH-2:0], step_q};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d       = rem_fix;
                    lo_d       = dz_q ? '1 : quo_fix;
                    div_zero_d = dz_q;
                end else begin
                    hi_d       = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d       = prod_fix[WIDTH-1:0];
                    div_zero_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush drops any accepted start and discards an uncommitted result.
        if (flush) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            hi_d       = hi_q;
            lo_d       = lo_q;
            div_zero_d = div_zero_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule
